ahb_irq_ctrl: RTL and testbench

//  AHB-Lite slave that collects peripheral interrupt sources (timer, UART, GPIO, spare),

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_src_cell.sv | 36 +++
 rtl/ahb_irq_ctrl.sv | 116 +++++++++++
 tb/tb_ahb_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants for the AHB interrupt controller
package irq_ctrl_pkg;

    localparam logic [2:0] REG_ENABLE    = 3'd0;
    localparam logic [2:0] REG_PENDING   = 3'd1;
    localparam logic [2:0] REG_MODE      = 3'd2;
    localparam logic [2:0] REG_ACTIVE_ID = 3'd3;
    localparam logic [2:0] REG_SWSET     = 3'd4;

    localparam logic [7:0] ID_NONE_DEFAULT = 8'hFF;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

endpackage

// File: rtl/irq_src_cell.sv
// rtl/irq_src_cell.sv - one interrupt source: input delay stage and pending bit
module irq_src_cell
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic w1c,
    input  logic swset,
    output logic pending
);

    logic src_q;

    // Edge mode: a new rising edge or software set wins over clear, clear wins over hold.
    // Level mode: the pending bit simply follows the raw source.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q <= src;
            if (mode == MODE_EDGE) begin
                if ((src && !src_q) || swset) begin
                    pending <= 1'b1;
                end else if (w1c) begin
                    pending <= 1'b0;
                end
            end else begin
                pending <= src;
            end
        end
    end

endmodule

// File: rtl/ahb_irq_ctrl.sv
// rtl/ahb_irq_ctrl.sv - AHB-Lite interrupt controller with pending/enable/mode registers
module ahb_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_IRQ = 4,
    parameter logic [7:0] ID_NONE = ID_NONE_DEFAULT
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    input  logic [NUM_IRQ-1:0] IRQ_SRC,
    output logic [NUM_IRQ-1:0] IRQ,
    output logic               IRQ_ANY
);

    logic [2:0]         addr_q;
    logic               wr_q;
    logic               valid_q;
    logic [NUM_IRQ-1:0] enable_r;
    logic [NUM_IRQ-1:0] mode_r;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] swset;
    logic [7:0]         active_id;
    logic               wr_en;

    // Address bits outside [4:2], transfer size and upper write data carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:NUM_IRQ]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Address phase capture; a new transfer is accepted in the same cycle a data phase ends
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= 3'd0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (HREADY) begin
            valid_q <= HSEL & HTRANS[1];
            if (HSEL & HTRANS[1]) begin
                addr_q <= HADDR[4:2];
                wr_q   <= HWRITE;
            end
        end
    end

    assign wr_en = valid_q & wr_q;
    assign w1c   = (wr_en && addr_q == REG_PENDING) ? HWDATA[NUM_IRQ-1:0] : '0;
    assign swset = (wr_en && addr_q == REG_SWSET)   ? HWDATA[NUM_IRQ-1:0] : '0;

    // ENABLE and MODE registers written in the data phase
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            enable_r <= '0;
            mode_r   <= '0;
        end else if (wr_en) begin
            if (addr_q == REG_ENABLE) begin
                enable_r <= HWDATA[NUM_IRQ-1:0];
            end
            if (addr_q == REG_MODE) begin
                mode_r <= HWDATA[NUM_IRQ-1:0];
            end
        end
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_cell
        irq_src_cell u_cell (
            .clk     (HCLK),
            .rst     (HRESET),
            .src     (IRQ_SRC[i]),
            .mode    (mode_r[i]),
            .w1c     (w1c[i]),
            .swset   (swset[i]),
            .pending (pending[i])
        );
    end

    assign IRQ     = pending & enable_r;
    assign IRQ_ANY = |IRQ;

    // Lowest-numbered active source wins
    always_comb begin
        active_id = ID_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (IRQ[i]) begin
                active_id = 8'(i);
            end
        end
    end

    // Read mux driven from the registered address during the data phase of a read
    always_comb begin
        HRDATA = '0;
        if (valid_q && !wr_q) begin
            case (addr_q)
                REG_ENABLE:    HRDATA[NUM_IRQ-1:0] = enable_r;
                REG_PENDING:   HRDATA[NUM_IRQ-1:0] = pending;
                REG_MODE:      HRDATA[NUM_IRQ-1:0] = mode_r;
                REG_ACTIVE_ID: HRDATA[7:0]         = active_id;
                default:       HRDATA              = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_irq_ctrl.sv
// tb/tb_ahb_irq_ctrl.sv - self-checking bench for ahb_irq_ctrl
module tb_ahb_irq_ctrl;

    localparam int         N    = 4;
    localparam logic [7:0] MASK = 8'h0F;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [N-1:0] IRQ_SRC;
    logic [N-1:0] IRQ;
    logic        IRQ_ANY;

    ahb_irq_ctrl #(.NUM_IRQ(N), .ID_NONE(8'hFF)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .IRQ_SRC   (IRQ_SRC),
        .IRQ       (IRQ),
        .IRQ_ANY   (IRQ_ANY)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0]  m_en, m_pend, m_mode, m_srcq;
    logic        m_wr_valid;
    logic [2:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    // transfer the bench issued last cycle (now in its data phase)
    logic        dp_valid, dp_wr;
    logic [2:0]  dp_addr;
    logic [31:0] d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_active();
        logic [7:0] act;
        logic [7:0] id;
        act = m_pend & m_en;
        id  = 8'hFF;
        for (int i = 0; i < N; i++) begin
            if (act[i] && id == 8'hFF) id = 8'(i);
        end
        return id;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'b0, m_en};
            3'd1:    return {24'b0, m_pend};
            3'd2:    return {24'b0, m_mode};
            3'd3:    return {24'b0, model_active()};
            default: return 32'b0;
        endcase
    endfunction

    // what one rising edge does to the registers, from the register-map rules
    task automatic model_edge();
        logic [7:0] src, w1c, sw, nxt;
        src = 8'(IRQ_SRC);
        if (HRESET) begin
            m_en = 0; m_pend = 0; m_mode = 0; m_srcq = 0;
        end else begin
            w1c = (m_wr_valid && m_wr_addr == 3'd1) ? (m_wr_data[7:0] & MASK) : 8'h0;
            sw  = (m_wr_valid && m_wr_addr == 3'd4) ? (m_wr_data[7:0] & MASK) : 8'h0;
            nxt = m_pend;
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) begin
                    if ((src[i] && !m_srcq[i]) || sw[i]) nxt[i] = 1'b1;
                    else if (w1c[i])                     nxt[i] = 1'b0;
                end else begin
                    nxt[i] = src[i];
                end
            end
            m_pend = nxt;
            m_srcq = src;
            if (m_wr_valid && m_wr_addr == 3'd0) m_en   = m_wr_data[7:0] & MASK;
            if (m_wr_valid && m_wr_addr == 3'd2) m_mode = m_wr_data[7:0] & MASK;
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    // one bus cycle: new address phase plus HWDATA for the previous transfer
    task automatic cyc(input logic sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
        logic rst_now;
        HSEL   = sel;
        HTRANS = sel ? 2'b10 : 2'b00;
        HWRITE = wr;
        HADDR  = addr;
        HWDATA = wdata;
        #2;
        if (dp_valid && !dp_wr) chk("hrdata", HRDATA, model_read(dp_addr));
        chk("irq", 32'(IRQ), 32'(m_pend & m_en));
        chk("irq_any", 32'(IRQ_ANY), 32'(|(m_pend & m_en)));
        chk("hreadyout", 32'(HREADYOUT), 32'd1);
        m_wr_valid = dp_valid && dp_wr;
        m_wr_addr  = dp_addr;
        m_wr_data  = wdata;
        rst_now    = HRESET;
        step();
        dp_valid = sel && !rst_now;
        dp_wr    = wr;
        dp_addr  = addr[4:2];
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b1, 1'b1, addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, data);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        cyc(1'b1, 1'b0, addr, 32'h0);
        data = HRDATA;
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        m_en = 0; m_pend = 0; m_mode = 0; m_srcq = 0;
        m_wr_valid = 0; m_wr_addr = 0; m_wr_data = 0;
        dp_valid = 0; dp_wr = 0; dp_addr = 0;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 0; HTRANS = 0; HWRITE = 0;
        HSIZE = 3'b010; HWDATA = 0; HREADY = 1'b1; IRQ_SRC = '0;
        step();

        // reset held across a write to ENABLE
        cyc(1'b1, 1'b1, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'hF);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        idle();
        HRESET = 1'b0;
        idle();
        rd(32'h0, d);
        chk("rst_enable", d, 32'h0);
        rd(32'hC, d);
        chk("rst_active_none", d, 32'hFF);

        // edge latch and write-1-to-clear
        wr(32'h8, 32'hF);
        wr(32'h0, 32'h1);
        IRQ_SRC = 4'h1;
        idle();
        IRQ_SRC = 4'h0;
        chk("edge_latch", 32'(IRQ), 32'h1);
        idle();
        chk("edge_hold", 32'(IRQ), 32'h1);
        wr(32'h4, 32'h1);
        chk("edge_w1c", 32'(IRQ), 32'h0);

        // priority encoding
        wr(32'h0, 32'hF);
        IRQ_SRC = 4'hA;
        idle();
        IRQ_SRC = 4'h0;
        rd(32'hC, d);
        chk("prio_1", d, 32'h1);
        wr(32'h4, 32'h2);
        rd(32'hC, d);
        chk("prio_3", d, 32'h3);
        wr(32'h4, 32'h8);
        rd(32'hC, d);
        chk("prio_none", d, 32'hFF);

        // a new edge beats a same-cycle clear
        IRQ_SRC = 4'h4;
        idle();
        IRQ_SRC = 4'h0;
        idle();
        cyc(1'b1, 1'b1, 32'h4, 32'h0);
        IRQ_SRC = 4'h4;
        cyc(1'b0, 1'b0, 32'h0, 32'h4);
        IRQ_SRC = 4'h0;
        chk("set_wins", 32'(IRQ & 4'h4), 32'h4);

        // level mode and masking
        wr(32'h8, 32'h0);
        wr(32'h0, 32'h0);
        IRQ_SRC = 4'h4;
        idle();
        rd(32'h4, d);
        chk("level_pending", d, 32'h4);
        chk("level_masked", 32'(IRQ), 32'h0);
        wr(32'h0, 32'h4);
        chk("level_unmasked", 32'(IRQ), 32'h4);
        IRQ_SRC = 4'h0;
        idle();
        chk("level_drop", 32'(IRQ), 32'h0);

        // back-to-back bus traffic and software set
        wr(32'h8, 32'hF);
        cyc(1'b1, 1'b1, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 32'h5);
        chk("b2b_rd_enable", HRDATA, 32'h5);
        cyc(1'b1, 1'b0, 32'h1C, 32'h0);
        chk("b2b_rd_unmapped", HRDATA, 32'h0);
        cyc(1'b1, 1'b1, 32'h10, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h2);
        rd(32'h4, d);
        chk("swset_pending", d, 32'h2);

        // randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            IRQ_SRC = N'($urandom);
            HRESET  = ($urandom_range(0, 99) == 0);
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), {27'b0, 3'($urandom), 2'b00},
                $urandom);
        end
        HRESET = 1'b0;
        IRQ_SRC = '0;
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
